pulse_meter: RTL and testbench
==============================

// Module: pulse_meter
// PURPOSE
//  Receive side of the DDS pulse generator: measures a single-bit pulse train (comparator output
//  or DDS DA_Data MSB loopback) in Clk cycles. Reports per-pulse high width and rising-to-rising
//  period, counts pulses up to a programmed number, flags completion or timeout. Sits beside
//  DDS_Module for self-test and external pulse verification.
// PARAMETERS
//  CNT_W        32        width of width/period counters (saturating)
//  NUM_W        16        width of pulse-number and pulse-count fields
//  TIMEOUT_CYC  50000000  max cycles waiting for any edge before abort (1 s at 50 MHz)
// PORTS
//  Clk         in   1      system clock, 50 MHz
//  Rst         in   1      synchronous reset, active-high
//  Arm         in   1      1-cycle strobe: clear results, load Num, start measuring
//  Num         in   NUM_W  pulses to measure; sampled on Arm
//  Pulse_In    in   1      asynchronous pulse input
//  Busy        out  1      1 from cycle after Arm until Done
//  Meas_Valid  out  1      1-cycle strobe: Width/Period/First valid
//  First       out  1      Meas_Valid refers to first pulse (Period not measured, reads 0)
//  Width       out  CNT_W  high time of last pulse, Clk cycles
//  Period      out  CNT_W  rising-to-rising time ending at last pulse, Clk cycles
//  Pulse_Cnt   out  NUM_W  pulses measured since Arm
//  Done        out  1      1-cycle strobe: Num pulses measured or timeout
//  Timeout     out  1      sticky; set with Done on timeout, cleared by Arm or Rst
// BEHAVIOUR
//  - Rst (synchronous, wins over all): state IDLE; every output and counter 0.
//  - Input path: 2-FF synchronizer + edge detector; rise/fall pulse asserted 3 Clk after input
//    edge. Measurements are edge-to-edge, so fixed latency cancels; tolerance +/-1 cycle.
//  - FSM: IDLE -> (Arm) WAIT_LOW -> (synced input low) WAIT_RISE -> (rise) HIGH -> (fall) LOW
//    -> (rise) HIGH ... ; after Num-th fall -> IDLE with Done.
//    WAIT_LOW ensures an input already high at Arm is not counted as a pulse.
//  - HIGH: width counter counts from 1 at the rise cycle. LOW and HIGH: period counter runs
//    from the last rise, restarting at 1 on each rise; value at rise latched as Period_next.
//  - On each fall in HIGH: Width<=width count, Period<=Period_next (0 for first pulse),
//    First<=(Pulse_Cnt==0), Pulse_Cnt++, Meas_Valid=1 for that cycle.
//  - Num-th fall: Meas_Valid and Done in the same cycle, Busy drops the next cycle.
//  - Num==0 on Arm: Done=1 the next cycle, no measurement, Busy stays 0.
//  - Counters saturate at all-ones; no wrap. Pulse_Cnt cannot exceed Num.
//  - Timeout: idle-edge counter resets on every sync edge and on Arm; in any non-IDLE state,
//    reaching TIMEOUT_CYC -> Timeout=1, Done=1, return IDLE; Width/Period/Pulse_Cnt hold.
//  - Arm while Busy: restart immediately (clear results, reload Num); no Done for aborted run.
//  - Arm in the same cycle as a rise: Arm wins; that edge is ignored (WAIT_LOW).
//  - Rise and fall in one cycle impossible after sync; pulses < 1 Clk high may be missed.
// STRUCTURE
//  - pulse_meter_pkg: state enum (IDLE, WAIT_LOW, WAIT_RISE, HIGH, LOW), CNT_SAT/NUM_W constants,
//    helper sat_inc function.
//  - Sub-module pulse_sync_edge: 2-FF synchronizer + registered rise/fall strobes + level out.
//  - Top: FSM, width/period/timeout counters, result registers.
// TESTING
//  1. DDS loopback, Fword for 10 kHz, Pwidth for 1000 ns, Num=10 -> 10 Meas_Valid, Width=50+/-1,
//     Period=5000+/-1 except First (Period=0), Done with 10th Meas_Valid, Pulse_Cnt=10.
//  2. Input held high at Arm, then 3 pulses of 20 cycles high/80 low, Num=2 -> first partial
//     pulse ignored; Width=20, Period=0 then 100; Done after 2nd fall.
//  3. Num=0 Arm -> Done one cycle later, Meas_Valid never, Busy never 1.
//  4. TIMEOUT_CYC=1000, one pulse then input stuck low, Num=5 -> Done+Timeout at 1000 cycles
//     after fall, Pulse_Cnt=1, Timeout holds until next Arm.
//  5. Arm again mid-run after 3 of 10 pulses -> results cleared, no Done from first run,
//     new run counts from 0.
//  6. Rst asserted while in HIGH -> next cycle all outputs 0, state IDLE, rise ignored until Arm.

Source files
------------

// File: rtl/pulse_meter_pkg.sv
// Shared types and helpers for the pulse meter: FSM states, default widths,
// and a saturating increment used by every counter in the block.
package pulse_meter_pkg;

  typedef enum logic [2:0] {IDLE, WAIT_LOW, WAIT_RISE, HIGH, LOW} state_e;

  localparam int unsigned DEF_CNT_W       = 32;
  localparam int unsigned DEF_NUM_W       = 16;
  localparam int unsigned DEF_TIMEOUT_CYC = 50_000_000;

  // Increment v, holding at the all-ones value of a w-bit field.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] lim;
    lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= lim) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/pulse_sync_edge.sv
// Two-flop synchronizer for an asynchronous level, with registered rise/fall
// strobes and a level output aligned to those strobes.
module pulse_sync_edge (
  input  logic Clk,
  input  logic Rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  // [0],[1] form the synchronizer; [2] is the previous synced value.
  logic [2:0] sync_pipe;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync_pipe <= '0;
      rise      <= 1'b0;
      fall      <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[1:0], din};
      rise      <=  sync_pipe[1] & ~sync_pipe[2];
      fall      <= ~sync_pipe[1] &  sync_pipe[2];
    end
  end

  assign level = sync_pipe[2];

endmodule

// File: rtl/pulse_meter.sv
// Measures high width and rise-to-rise period of a pulse train for a programmed
// number of pulses, with an edge-inactivity timeout.
module pulse_meter
  import pulse_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned NUM_W       = DEF_NUM_W,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Arm,
  input  logic [NUM_W-1:0] Num,
  input  logic             Pulse_In,
  output logic             Busy,
  output logic             Meas_Valid,
  output logic             First,
  output logic [CNT_W-1:0] Width,
  output logic [CNT_W-1:0] Period,
  output logic [NUM_W-1:0] Pulse_Cnt,
  output logic             Done,
  output logic             Timeout
);

  localparam int unsigned     TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  state_e           state, state_nx;
  logic             lvl, rise, fall;
  logic [NUM_W-1:0] num_q;
  logic [CNT_W-1:0] width_cnt, per_cnt, per_next;
  logic [TO_W-1:0]  to_cnt;
  logic             meas_evt, last_fall, to_hit, done_evt;

  pulse_sync_edge u_sync (
    .Clk   (Clk),
    .Rst   (Rst),
    .din   (Pulse_In),
    .level (lvl),
    .rise  (rise),
    .fall  (fall)
  );

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Arm overrides everything, including an edge arriving in the same cycle.
  always_comb begin
    state_nx = state;
    if (Arm)         state_nx = (Num == '0) ? IDLE : WAIT_LOW;
    else if (to_hit) state_nx = IDLE;
    else begin
      case (state)
        WAIT_LOW:  if (!lvl) state_nx = WAIT_RISE;
        WAIT_RISE: if (rise) state_nx = HIGH;
        HIGH:      if (fall) state_nx = last_fall ? IDLE : LOW;
        LOW:       if (rise) state_nx = HIGH;
        default:   state_nx = state;
      endcase
    end
  end

  always_comb begin
    meas_evt  = !Arm && (state == HIGH) && fall;
    last_fall = (Pulse_Cnt == num_q - NUM_W'(1));
    to_hit    = !Arm && (state != IDLE) && !rise && !fall && (to_cnt == TO_LAST);
    done_evt  = (meas_evt && last_fall) || to_hit;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      num_q      <= '0;
      width_cnt  <= '0;
      per_cnt    <= '0;
      per_next   <= '0;
      to_cnt     <= '0;
      Width      <= '0;
      Period     <= '0;
      Pulse_Cnt  <= '0;
      First      <= 1'b0;
      Meas_Valid <= 1'b0;
      Done       <= 1'b0;
      Timeout    <= 1'b0;
      Busy       <= 1'b0;
    end else if (Arm) begin
      num_q      <= Num;
      width_cnt  <= '0;
      per_cnt    <= '0;
      per_next   <= '0;
      to_cnt     <= '0;
      Width      <= '0;
      Period     <= '0;
      Pulse_Cnt  <= '0;
      First      <= 1'b0;
      Meas_Valid <= 1'b0;
      Done       <= (Num == '0);
      Timeout    <= 1'b0;
      Busy       <= (Num != '0);
    end else begin
      Meas_Valid <= meas_evt;
      Done       <= done_evt;
      // Busy stays up through the Done cycle and drops after it.
      if (Done) Busy <= 1'b0;
      if (to_hit) Timeout <= 1'b1;

      if (state == IDLE || rise || fall) to_cnt <= '0;
      else                               to_cnt <= TO_W'(sat_inc(64'(to_cnt), TO_W));

      if (rise)               width_cnt <= CNT_W'(1);
      else if (state == HIGH) width_cnt <= CNT_W'(sat_inc(64'(width_cnt), CNT_W));

      if (rise)                                per_cnt <= CNT_W'(1);
      else if (state == HIGH || state == LOW)  per_cnt <= CNT_W'(sat_inc(64'(per_cnt), CNT_W));
      if (rise && state == LOW)                per_next <= per_cnt;

      if (meas_evt) begin
        Width     <= width_cnt;
        Period    <= (Pulse_Cnt == '0) ? '0 : per_next;
        First     <= (Pulse_Cnt == '0);
        Pulse_Cnt <= NUM_W'(sat_inc(64'(Pulse_Cnt), NUM_W));
      end
    end
  end

endmodule

// File: tb/tb_pulse_meter.sv
// Directed bench for pulse_meter: pulse tables with hand-computed widths and
// periods, plus sequences for Arm-while-high, Num=0, timeout, re-arm and reset.
module tb_pulse_meter;

  logic        Clk, Rst, Arm, Pulse_In;
  logic [15:0] Num;
  logic        Busy, Meas_Valid, First, Done, Timeout;
  logic [31:0] Width, Period;
  logic [15:0] Pulse_Cnt;

  pulse_meter #(.CNT_W(32), .NUM_W(16), .TIMEOUT_CYC(1000)) dut (
    .Clk(Clk), .Rst(Rst), .Arm(Arm), .Num(Num), .Pulse_In(Pulse_In),
    .Busy(Busy), .Meas_Valid(Meas_Valid), .First(First), .Width(Width),
    .Period(Period), .Pulse_Cnt(Pulse_Cnt), .Done(Done), .Timeout(Timeout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] w;
    logic [31:0] p;
    logic        f;
    logic        d;
    logic [15:0] pc;
    int          cyc;
  } rec_t;

  typedef struct {
    int hi; int lo; bit meas; int ew; int ep; bit ef; bit ed;
  } vec_t;

  rec_t recs[64];
  vec_t tbl[$];
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0, busy_cnt = 0, meas_n = 0, done_n = 0, done_cyc = 0;
  bit   done_busy = 0;

  // Output monitor, sampling 2 ns after each rising edge.
  always begin
    @(posedge Clk); #2;
    cyc++;
    if (Busy) busy_cnt++;
    if (Meas_Valid && meas_n < 64) begin
      recs[meas_n] = '{Width, Period, First, Done, Pulse_Cnt, cyc};
      meas_n++;
    end
    if (Done) begin
      done_n++;
      done_cyc  = cyc;
      done_busy = Busy;
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic arm(input int num);
    @(negedge Clk); Arm = 1'b1; Num = 16'(num);
    @(negedge Clk); Arm = 1'b0;
  endtask

  task automatic pulse(input int hi, input int lo);
    Pulse_In = 1'b1; tick(hi);
    Pulse_In = 1'b0; tick(lo);
  endtask

  task automatic add(input int hi, input int lo, input bit m, input int ew, input int ep,
                     input bit ef, input bit ed);
    vec_t v;
    v = '{hi, lo, m, ew, ep, ef, ed};
    tbl.push_back(v);
  endtask

  task automatic apply_tbl();
    foreach (tbl[i]) pulse(tbl[i].hi, tbl[i].lo);
  endtask

  task automatic check_tbl(input string tag, input int base);
    int k = base;
    foreach (tbl[i]) begin
      if (tbl[i].meas) begin
        chk({tag, "_width"},  recs[k].w, tbl[i].ew);
        chk({tag, "_period"}, recs[k].p, tbl[i].ep);
        chk({tag, "_first"},  recs[k].f, tbl[i].ef);
        chk({tag, "_done"},   recs[k].d, tbl[i].ed);
        k++;
      end
    end
    chk({tag, "_nmeas"}, meas_n - base, k - base);
  endtask

  initial begin
    int mb, db, bb, gap;
    Rst = 1'b1; Arm = 1'b0; Num = '0; Pulse_In = 1'b0;
    tick(3);
    chk("rst_busy", Busy, 0);      chk("rst_valid", Meas_Valid, 0);
    chk("rst_width", Width, 0);    chk("rst_period", Period, 0);
    chk("rst_cnt", Pulse_Cnt, 0);  chk("rst_done", Done, 0);
    chk("rst_timeout", Timeout, 0);
    Rst = 1'b0; tick(2);

    // Four pulses of varying shape; period = previous hi + lo.
    mb = meas_n; db = done_n;
    arm(4); tick(2);
    tbl.delete();
    add(10, 30, 1, 10,  0, 1, 0);
    add(20, 15, 1, 20, 40, 0, 0);
    add( 7,  9, 1,  7, 35, 0, 0);
    add( 3, 20, 1,  3, 16, 0, 1);
    apply_tbl(); tick(5);
    check_tbl("seqA", mb);
    chk("seqA_cnt", Pulse_Cnt, 4);
    chk("seqA_ndone", done_n - db, 1);
    chk("seqA_busy_at_done", done_busy, 1);
    chk("seqA_busy_after", Busy, 0);

    // Input already high at Arm: partial pulse ignored, third pulse after Done ignored.
    Pulse_In = 1'b1; tick(5);
    mb = meas_n; db = done_n;
    arm(2); tick(10); Pulse_In = 1'b0; tick(80);
    tbl.delete();
    add(20, 80, 1, 20,   0, 1, 0);
    add(20, 80, 1, 20, 100, 0, 1);
    add(20, 80, 0,  0,   0, 0, 0);
    apply_tbl(); tick(5);
    check_tbl("hiArm", mb);
    chk("hiArm_cnt", Pulse_Cnt, 2);
    chk("hiArm_ndone", done_n - db, 1);

    // One pulse then silence: timeout 1000 cycles after the measurement.
    mb = meas_n; db = done_n;
    arm(5); tick(2); pulse(10, 0); tick(1100);
    chk("to_nmeas", meas_n - mb, 1);
    chk("to_ndone", done_n - db, 1);
    chk("to_flag", Timeout, 1);
    chk("to_cnt", Pulse_Cnt, 1);
    chk("to_width", Width, 10);
    chk("to_busy", Busy, 0);
    gap = done_cyc - recs[mb].cyc;
    n_cmp++;
    if (gap < 999 || gap > 1001) begin
      n_bad++;
      $display("FAIL to_latency: got %0d expected 1000 +/-1", gap);
    end
    tick(20);
    chk("to_sticky", Timeout, 1);

    // Num=0: Done the next cycle, no Busy, and Arm clears Timeout.
    mb = meas_n; db = done_n; bb = busy_cnt;
    arm(0);
    chk("num0_done", Done, 1);
    chk("num0_busy", Busy, 0);
    chk("num0_to_clr", Timeout, 0);
    tick(1);
    chk("num0_done_strobe", Done, 0);
    tick(10);
    chk("num0_busy_never", busy_cnt - bb, 0);
    chk("num0_nmeas", meas_n - mb, 0);
    chk("num0_ndone", done_n - db, 1);

    // Re-arm after 3 of 10 pulses: results cleared, only the new run finishes.
    db = done_n;
    arm(10); tick(2);
    repeat (3) pulse(10, 20);
    chk("rearm_pre_cnt", Pulse_Cnt, 3);
    arm(2);
    chk("rearm_cnt", Pulse_Cnt, 0);
    chk("rearm_width", Width, 0);
    chk("rearm_busy", Busy, 1);
    mb = meas_n; tick(2);
    tbl.delete();
    add(15, 15, 1, 15,  0, 1, 0);
    add(15, 15, 1, 15, 30, 0, 1);
    apply_tbl(); tick(5);
    check_tbl("rearm", mb);
    chk("rearm_ndone", done_n - db, 1);

    // Reset while in HIGH: everything clears and later edges are ignored.
    arm(5); tick(2); pulse(10, 10);
    Pulse_In = 1'b1; tick(5);
    chk("rst_pre_width", Width, 10);
    Rst = 1'b1; tick(1); Rst = 1'b0;
    chk("rstH_width", Width, 0);   chk("rstH_cnt", Pulse_Cnt, 0);
    chk("rstH_busy", Busy, 0);     chk("rstH_first", First, 0);
    chk("rstH_done", Done, 0);     chk("rstH_valid", Meas_Valid, 0);
    mb = meas_n; bb = busy_cnt; db = done_n;
    tick(5); Pulse_In = 1'b0; tick(5);
    pulse(10, 10); tick(5);
    chk("rstH_nmeas", meas_n - mb, 0);
    chk("rstH_busy_after", busy_cnt - bb, 0);
    chk("rstH_ndone", done_n - db, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
